// File: rtl/mult_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mult_arbiter_pkg
// Shared definitions for the round-robin multiplier arbiter.
//   DEF_N      default operand width (signed two's complement)
//   DEF_R      default number of requesters (power of two, >= 2)
//   DEF_IW     index width that addresses DEF_R requesters
//   state_t    arbiter FSM encoding (IDLE / MUL / DONE)
//   idx_width  helper that turns a requester count into an index width
// ---------------------------------------------------------------------------
package mult_arbiter_pkg;

   localparam int DEF_N = 5;
   localparam int DEF_R = 4;

   // A single requester would still need one index bit so that out_id never
   // collapses to a zero-width port.
   function automatic int idx_width(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

   localparam int DEF_IW = idx_width(DEF_R);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_arbiter_mult.sv
// ---------------------------------------------------------------------------
// mult_arbiter_mult
// Purely combinational signed multiplier producing the full-width product.
//   N  operand width
//   a  signed multiplicand, N bits
//   b  signed multiplier,   N bits
//   p  signed product,      2N bits, never truncated or saturated
// ---------------------------------------------------------------------------
module mult_arbiter_mult #(
   parameter int N = 5
) (
   input  logic signed [N-1:0]   a,
   input  logic signed [N-1:0]   b,
   output logic signed [2*N-1:0] p
);

   // Both operands are signed and the result is 2N wide, so the operands are
   // sign-extended before multiplying and the most negative square still fits.
   always_comb begin
      p = a * b;
   end

endmodule

// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
// Round-robin arbiter in front of a single shared signed multiplier. One
// requester is granted from IDLE, its operands are captured, the product is
// registered in MUL and presented in DONE until the consumer accepts it.
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request level, R bits
//   x_in       packed x operands, slice [i*N +: N] belongs to requester i
//   y_in       packed y operands, same slicing as x_in
//   gnt        one-hot grant, all zero when nothing is granted
//   out_valid  result present on out_data / out_id
//   out_id     index of the requester owning the result
//   out_data   signed 2N-bit product
//   out_ready  consumer accepts the result (only meaningful in DONE)
// ---------------------------------------------------------------------------
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int R  = DEF_R,
   localparam int IW = idx_width(R)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [R-1:0]          req,
   input  logic [R*N-1:0]        x_in,
   input  logic [R*N-1:0]        y_in,
   output logic [R-1:0]          gnt,
   output logic                  out_valid,
   output logic [IW-1:0]         out_id,
   output logic signed [2*N-1:0] out_data,
   input  logic                  out_ready
);

   state_t state;
   state_t state_nxt;

   logic [IW-1:0]         rr_ptr;
   logic [IW-1:0]         pick_idx;
   logic [IW-1:0]         cand;
   logic                  pick_any;
   logic                  grant_fire;
   logic                  accept;

   logic signed [N-1:0]   x_sel;
   logic signed [N-1:0]   y_sel;
   logic signed [N-1:0]   x_reg;
   logic signed [N-1:0]   y_reg;
   logic [IW-1:0]         id_reg;
   logic signed [2*N-1:0] product;

   // Round-robin search starting at rr_ptr. Because R is a power of two the
   // IW-bit addition wraps modulo R on its own, so no explicit modulo is needed.
   always_comb begin
      pick_idx = '0;
      pick_any = 1'b0;
      cand     = '0;
      for (int k = 0; k < R; k++) begin
         cand = rr_ptr + IW'(k);
         if (!pick_any && req[cand]) begin
            pick_any = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Operand slices of whichever requester the picker chose; these are only
   // captured on the grant edge, so later input changes cannot leak in.
   always_comb begin
      x_sel = x_in[pick_idx*N +: N];
      y_sel = y_in[pick_idx*N +: N];
   end

   // A grant happens only from IDLE; an accept only from DONE, which is what
   // makes out_ready harmless in the other states.
   always_comb begin
      grant_fire = (state == IDLE) && pick_any;
      accept     = (state == DONE) && out_ready;
   end

   // State register. Reset drops any in-flight transaction by returning to
   // IDLE immediately, so nothing is delivered for it after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> MUL on grant, MUL -> DONE unconditionally,
   // DONE -> IDLE when the consumer accepts.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_fire) state_nxt = MUL;
         MUL:     state_nxt = DONE;
         DONE:    if (accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore-style outputs plus the combinational grant. The grant is also
   // gated by rst_n so that a held request cannot show up on gnt while the
   // block is in reset.
   always_comb begin
      gnt       = '0;
      out_valid = (state == DONE);
      if (rst_n && grant_fire) begin
         gnt[pick_idx] = 1'b1;
      end
   end

   // Operand and index capture on the grant edge. The multiplier reads only
   // these registers, never the live inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg  <= '0;
         y_reg  <= '0;
         id_reg <= '0;
      end else if (grant_fire) begin
         x_reg  <= x_sel;
         y_reg  <= y_sel;
         id_reg <= pick_idx;
      end
   end

   mult_arbiter_mult #(
      .N (N)
   ) u_mult (
      .a (x_reg),
      .b (y_reg),
      .p (product)
   );

   // Result registers load during MUL and are otherwise left alone, which
   // keeps them stable for as long as DONE is backpressured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_id   <= '0;
      end else if (state == MUL) begin
         out_data <= product;
         out_id   <= id_reg;
      end
   end

   // The search pointer moves just past the requester that was served, so
   // a continuously requesting set is visited in strict rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= out_id + IW'(1);
      end
   end

endmodule
